// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the c_mem request interface, with a completion pulse and a
// programmable access latency. Optional out-of-range error reporting is enabled by DMEM_RESP_ERR_EN.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        masking,
  input  logic              we_re,
  input  logic [31:0]       w_data,
  output logic [31:0]       r_data,
  output logic              valid,
  output logic              busy,
  output logic              err
);
  // state | meaning
  // IDLE  | waiting for request; inputs latched on acceptance
  // WAIT  | latency down-counter running, request ignored
  // RESP  | access performed on entry; valid and busy high for this one cycle

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam bit         LAT_ZERO = (LATENCY == 0);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept;
  logic              do_access;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q;
  logic              we_q;
  logic [31:0]       wdata_q;

  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_mask;
  logic              acc_we;
  logic [31:0]       acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_oor;

  logic [31:0]       mem [DEPTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          accept = 1'b1;
          if (LAT_ZERO) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          do_access = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the access happens on the acceptance edge, before the latches are loaded.
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = address;
      acc_mask  = masking;
      acc_we    = we_re;
      acc_wdata = w_data;
    end else begin
      acc_addr  = addr_q;
      acc_mask  = mask_q;
      acc_we    = we_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx = acc_addr[IDX_W-1:0];

`ifdef DMEM_RESP_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  logic err_q;

  assign acc_oor = ({1'b0, acc_addr} >= DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (do_access) begin
      err_q <= acc_oor;
    end
  end

  assign err = valid & err_q;
`else
  assign acc_oor = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      r_data <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_access && !acc_we) begin
        r_data <= acc_oor ? 32'd0 : mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address;
      mask_q  <= masking;
      we_q    <= we_re;
      wdata_q <= w_data;
    end
  end

  // RAM is never cleared; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_we && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign valid = (state == RESP);
  assign busy  = (state != IDLE);

endmodule
